// File: rtl/timer_hms_counter_pkg.sv
// Shared types and constants for the H:M:S running timer.
// Holds the FSM state encoding and the packed-BCD increment helper.
package timer_hms_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] BCD_59   = 8'h59;
    localparam logic [7:0] BCD_ZERO = 8'h00;

    // Next two-digit packed-BCD value; wraps to zero once max is reached.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        logic [7:0] r;
        if (v == max) begin
            r = BCD_ZERO;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/timer_hms_counter_bcd2_counter.sv
// Two-digit packed-BCD counter that wraps at MAX.
// carry is combinational so that chained stages all update on the same edge.
module bcd2_counter
    import timer_hms_counter_pkg::*;
#(
    parameter logic [7:0] MAX = BCD_59
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] value,
    output logic       carry
);

    logic [7:0] r_value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_value <= BCD_ZERO;
        end else if (clr) begin
            r_value <= BCD_ZERO;
        end else if (inc) begin
            r_value <= bcd_inc(r_value, MAX);
        end
    end

    assign value = r_value;
    assign carry = inc && (r_value == MAX);

endmodule

// File: rtl/timer_hms_counter.sv
// Running H:M:S counter with start/stop/clear control; freezes on comparator match.
// The FSM arbitrates clear > fin > stop > start > tick and drives the chained BCD stages.
module timer_hms_counter
    import timer_hms_counter_pkg::*;
#(
    parameter logic [7:0] MAX_H = 8'h23
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       fin,
    output logic [7:0] CcountH,
    output logic [7:0] CcountM,
    output logic [7:0] CcountS,
    output logic       en_cmp,
    output logic       running,
    output logic       done
);

    state_t r_state;
    state_t w_state_next;
    logic   w_adv;
    logic   w_carry_s;
    logic   w_carry_m;
    logic   w_unused_carry_h;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_adv        = 1'b0;
        if (clear) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (start) w_state_next = ST_RUN;
                // fin beats the tick, so a match never overshoots by one second.
                ST_RUN: begin
                    if (fin) begin
                        w_state_next = ST_DONE;
                    end else if (stop) begin
                        w_state_next = ST_PAUSE;
                    end else if (tick_1hz) begin
                        w_adv = 1'b1;
                    end
                end
                ST_PAUSE: if (start) w_state_next = ST_RUN;
                ST_DONE:  w_state_next = ST_DONE;
                default:  w_state_next = ST_IDLE;
            endcase
        end
    end

    bcd2_counter #(.MAX(BCD_59)) u_sec (
        .clock (clock),
        .reset (reset),
        .inc   (w_adv),
        .clr   (clear),
        .value (CcountS),
        .carry (w_carry_s)
    );

    bcd2_counter #(.MAX(BCD_59)) u_min (
        .clock (clock),
        .reset (reset),
        .inc   (w_carry_s),
        .clr   (clear),
        .value (CcountM),
        .carry (w_carry_m)
    );

    bcd2_counter #(.MAX(MAX_H)) u_hour (
        .clock (clock),
        .reset (reset),
        .inc   (w_carry_m),
        .clr   (clear),
        .value (CcountH),
        .carry (w_unused_carry_h)
    );

    assign running = (r_state == ST_RUN);
    assign en_cmp  = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_timer_hms_counter.sv
// Bench for timer_hms_counter: an elapsed-seconds model checked every cycle,
// plus literal checkpoints. Hours wrap at a reduced MAX_H to keep the full-wrap run short.
module tb_timer_hms_counter;

    localparam logic [7:0] TB_MAX_H = 8'h02;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick_1hz, start, stop, clear, fin;
    logic [7:0] CcountH, CcountM, CcountS;
    logic       en_cmp, running, done;

    int checks = 0;
    int errors = 0;

    // Model: elapsed seconds plus a mode (0 idle, 1 run, 2 pause, 3 done).
    int m_secs = 0;
    int m_mode = 0;
    bit chk_en = 1'b0;

    timer_hms_counter #(.MAX_H(TB_MAX_H)) dut (
        .clock    (clock),
        .reset    (reset),
        .tick_1hz (tick_1hz),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .fin      (fin),
        .CcountH  (CcountH),
        .CcountM  (CcountM),
        .CcountS  (CcountS),
        .en_cmp   (en_cmp),
        .running  (running),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

    function automatic int day_secs();
        return (int'(TB_MAX_H[7:4]) * 10 + int'(TB_MAX_H[3:0]) + 1) * 3600;
    endfunction

    function automatic logic [7:0] exp_h(); return to_bcd(m_secs / 3600);       endfunction
    function automatic logic [7:0] exp_m(); return to_bcd((m_secs / 60) % 60);  endfunction
    function automatic logic [7:0] exp_s(); return to_bcd(m_secs % 60);         endfunction

    task automatic model_step(input logic t, input logic s, input logic p,
                              input logic c, input logic f);
        if (c) begin
            m_mode = 0;
            m_secs = 0;
        end else begin
            case (m_mode)
                0: if (s) m_mode = 1;
                1: begin
                    if (f)      m_mode = 3;
                    else if (p) m_mode = 2;
                    else if (t) m_secs = (m_secs + 1) % day_secs();
                end
                2: if (s) m_mode = 1;
                default: ;
            endcase
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            checks++;
            if (CcountH !== exp_h() || CcountM !== exp_m() || CcountS !== exp_s() ||
                running !== (m_mode == 1) || en_cmp !== (m_mode == 1) || done !== (m_mode == 3)) begin
                errors++;
                $display("FAIL model_cmp t=%0t got %h:%h:%h run=%b en=%b done=%b exp %h:%h:%h run=%b en=%b done=%b",
                         $time, CcountH, CcountM, CcountS, running, en_cmp, done,
                         exp_h(), exp_m(), exp_s(), m_mode == 1, m_mode == 1, m_mode == 3);
            end
        end
    end

    task automatic cyc(input logic t, input logic s, input logic p,
                       input logic c, input logic f);
        tick_1hz = t; start = s; stop = p; clear = c; fin = f;
        @(posedge clock);
        model_step(t, s, p, c, f);
        @(negedge clock);
        tick_1hz = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; fin = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Literal checkpoint: pins both the DUT and the model to a hand-computed value.
    task automatic lit(input string name, input logic [7:0] h, input logic [7:0] m,
                       input logic [7:0] s, input logic run, input logic dn);
        checks++;
        if (CcountH !== h || CcountM !== m || CcountS !== s || running !== run ||
            en_cmp !== run || done !== dn || exp_h() !== h || exp_m() !== m ||
            exp_s() !== s || (m_mode == 1) !== run || (m_mode == 3) !== dn) begin
            errors++;
            $display("FAIL %s got %h:%h:%h run=%b en=%b done=%b model %h:%h:%h mode=%0d required %h:%h:%h run=%b done=%b",
                     name, CcountH, CcountM, CcountS, running, en_cmp, done,
                     exp_h(), exp_m(), exp_s(), m_mode, h, m, s, run, dn);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        tick_1hz = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0; fin = 1'b0;
        repeat (3) @(negedge clock);
        lit("reset_state", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        chk_en = 1'b1;

        cyc(0, 0, 0, 0, 1);
        lit("fin_in_idle_ignored", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(0, 1, 0, 0, 0);
        ticks(7);
        lit("run_7s", 8'h00, 8'h00, 8'h07, 1'b1, 1'b0);

        // Asynchronous reset mid-run, well away from the clock edge.
        #2 reset = 1'b0;
        #1 m_mode = 0; m_secs = 0;
        lit("async_reset", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        cyc(0, 1, 0, 0, 0);
        ticks(1);
        lit("after_reset_1s", 8'h00, 8'h00, 8'h01, 1'b1, 1'b0);

        cyc(0, 0, 0, 1, 0);
        lit("clear_idle", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(0, 1, 0, 0, 0);
        ticks(60);
        lit("sixty_ticks", 8'h00, 8'h01, 8'h00, 1'b1, 1'b0);
        ticks(549);
        lit("minute_digit_carry", 8'h00, 8'h10, 8'h09, 1'b1, 1'b0);

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(3 * 3600 - 1);
        lit("max_time", 8'h02, 8'h59, 8'h59, 1'b1, 1'b0);
        ticks(1);
        lit("full_wrap", 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(5);
        cyc(0, 0, 1, 0, 0);
        ticks(3);
        lit("paused_hold", 8'h00, 8'h00, 8'h05, 1'b0, 1'b0);
        cyc(0, 1, 0, 0, 0);
        ticks(1);
        lit("resume_6s", 8'h00, 8'h00, 8'h06, 1'b1, 1'b0);
        cyc(1, 1, 1, 0, 0);
        lit("start_stop_in_run", 8'h00, 8'h00, 8'h06, 1'b0, 1'b0);
        cyc(0, 1, 1, 0, 0);
        lit("start_stop_in_pause", 8'h00, 8'h00, 8'h06, 1'b1, 1'b0);
        cyc(1, 0, 1, 0, 0);
        lit("stop_beats_tick", 8'h00, 8'h00, 8'h06, 1'b0, 1'b0);

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(10);
        lit("match_value", 8'h00, 8'h00, 8'h10, 1'b1, 1'b0);
        cyc(0, 0, 0, 0, 1);
        lit("done_on_fin", 8'h00, 8'h00, 8'h10, 1'b0, 1'b1);
        ticks(3);
        cyc(0, 1, 0, 0, 0);
        lit("done_frozen", 8'h00, 8'h00, 8'h10, 1'b0, 1'b1);
        cyc(0, 0, 0, 1, 0);
        lit("clear_from_done", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        cyc(0, 1, 0, 0, 0);
        ticks(3);
        cyc(1, 0, 0, 0, 1);
        lit("fin_beats_tick", 8'h00, 8'h00, 8'h03, 1'b0, 1'b1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(2);
        cyc(1, 0, 0, 1, 1);
        lit("clear_beats_fin", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

        @(negedge clock);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
